// File: rtl/sys1_input_pkg.sv
// Shared types and helpers for the System 1 spinner/dial input path.
package sys1_input_pkg;

  localparam int POS_W  = 12;
  localparam int FRAC_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    CRUISE = 2'd2
  } dial_state_t;

  // Sign-extend an 8-bit relative delta to position width, then scale it.
  function automatic logic [POS_W-1:0] sext_delta(input logic [7:0] d,
                                                  input int unsigned sh);
    logic [POS_W-1:0] x;
    x = {{(POS_W-8){d[7]}}, d};
    return x << sh;
  endfunction

endpackage

// File: rtl/sys1_toggle_det.sv
// Toggle-bit sample detector for one spinner/mouse source.
module sys1_toggle_det (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] spin_in,
  output logic       hit,
  output logic [7:0] delta
);

  logic prev;

  // During reset prev tracks the input too, so a pending toggle is absorbed.
  always_ff @(posedge clk) begin
    if (reset) prev <= spin_in[8];
    else       prev <= spin_in[8];
  end

  assign hit   = spin_in[8] ^ prev;
  assign delta = spin_in[7:0];

endmodule

// File: rtl/sys1_dial.sv
// Positional dial: accelerated digital plus/minus merged with two relative
// spinner sources into one wrapping 8.4 fixed-point position.
module sys1_dial
  import sys1_input_pkg::*;
#(
  parameter int unsigned V_MIN     = 4,
  parameter int unsigned V_MAX     = 16,
  parameter int unsigned V_FAST    = 32,
  parameter int unsigned V_ACC     = 1,
  parameter int unsigned ANA_SHIFT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       plus,
  input  logic       minus,
  input  logic       fast,
  input  logic       strobe,
  input  logic [8:0] spin1_in,
  input  logic [8:0] spin2_in,
  output logic [7:0] dial_out,
  output logic       moving
);

  localparam int NUM_SRC = 2;
  localparam logic [7:0] VMIN8  = 8'(V_MIN);
  localparam logic [7:0] VMAX8  = 8'(V_MAX);
  localparam logic [7:0] VFAST8 = 8'(V_FAST);
  localparam logic [7:0] VACC8  = 8'(V_ACC);

  logic [NUM_SRC-1:0][8:0] spin_in;
  logic [NUM_SRC-1:0]      hit;
  logic [NUM_SRC-1:0][7:0] delta;

  assign spin_in = {spin2_in, spin1_in};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sys1_toggle_det u_tdet (
      .clk     (clk),
      .reset   (reset),
      .spin_in (spin_in[i]),
      .hit     (hit[i]),
      .delta   (delta[i])
    );
  end

  dial_state_t      state, state_n;
  logic [7:0]       vel, vel_n;
  logic             dir, dir_n;       // 1 = plus
  logic             strobe_q;
  logic [POS_W-1:0] pos, pos_n;

  logic             strobe_edge;
  logic [7:0]       lim;
  logic [8:0]       ramp_v;
  logic [7:0]       ramp_sat;
  logic [POS_W-1:0] dig_step;
  logic [NUM_SRC-1:0][POS_W-1:0] ana_step;

  assign strobe_edge = strobe & ~strobe_q;
  assign lim         = fast ? VFAST8 : VMAX8;

  always_comb begin
    state_n  = state;
    vel_n    = vel;
    dir_n    = dir;
    dig_step = '0;
    ramp_v   = {1'b0, vel} + {1'b0, VACC8};
    ramp_sat = (ramp_v >= {1'b0, lim}) ? lim : ramp_v[7:0];
    if (strobe_edge) begin
      if (plus ^ minus) begin
        if (state == IDLE || plus != dir) begin
          state_n = RAMP;
          vel_n   = VMIN8;
          dir_n   = plus;
        end else begin
          case (state)
            RAMP: begin
              vel_n   = ramp_sat;
              state_n = (ramp_sat == lim) ? CRUISE : RAMP;
            end
            CRUISE: begin
              if (lim > vel) begin
                vel_n   = ramp_sat;
                state_n = RAMP;
              end else if (lim < vel) begin
                vel_n   = lim;
              end
            end
            default: ;
          endcase
        end
        dig_step = plus ? {4'b0, vel_n} : (POS_W'(0) - {4'b0, vel_n});
      end else begin
        state_n = IDLE;
        vel_n   = '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      ana_step[i] = hit[i] ? sext_delta(delta[i], ANA_SHIFT) : '0;
    // Digital and both analog contributions land in one update; wrap is natural.
    pos_n = pos + dig_step + ana_step[0] + ana_step[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos      <= '0;
      vel      <= '0;
      state    <= IDLE;
      dir      <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      pos      <= pos_n;
      vel      <= vel_n;
      state    <= state_n;
      dir      <= dir_n;
      strobe_q <= strobe;
    end
  end

  assign dial_out = pos[POS_W-1:FRAC_W];
  assign moving   = (state != IDLE);

endmodule
